countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 149 ++++++++++++++
 tb/tb_countdown_timer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Countdown timer with BCD display digits M:SS.d.
//
// A prescaler divides the clock down to one tick per tenth of a second; each tick
// decrements the BCD count with borrow. The FSM (Idle/Run/Pause/Done) gates the
// prescaler and reports status. Loading is allowed in every state and wins over run.
//
// Ports:
//   clock                 single clock, rising edge
//   reset                 asynchronous active-low reset
//   load                  latch preset digits (clamped to valid BCD)
//   load_minutes/sec_high/sec_low/tenths  preset digits
//   run                   level: count while high, pause while low
//   minutes/sec_high/sec_low/tenths      registered remaining time
//   running               registered, high in Run
//   expired               registered, high in Done
//   done                  registered one-cycle pulse on reaching 0:00.0
module countdown_timer #(
  parameter int unsigned TICKS_PER_TENTH = 10000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_minutes,
  input  logic [3:0] load_sec_high,
  input  logic [3:0] load_sec_low,
  input  logic [3:0] load_tenths,
  input  logic       run,
  output logic [3:0] minutes,
  output logic [3:0] sec_high,
  output logic [3:0] sec_low,
  output logic [3:0] tenths,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned PresW = (TICKS_PER_TENTH > 1) ? $clog2(TICKS_PER_TENTH) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(TICKS_PER_TENTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       min_q, min_d, sh_q, sh_d, sl_q, sl_d, t_q, t_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic             running_q, running_d, expired_q, expired_d, done_q, done_d;

  logic tick, count_zero, count_one;

  assign tick       = (presc_q == PresMax);
  assign count_zero = (min_q == 4'd0) && (sh_q == 4'd0) && (sl_q == 4'd0) && (t_q == 4'd0);
  assign count_one  = (min_q == 4'd0) && (sh_q == 4'd0) && (sl_q == 4'd0) && (t_q == 4'd1);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sh_d    = sh_q;
    sl_d    = sl_q;
    t_d     = t_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (load) begin
      min_d   = (load_minutes > 4'd9)  ? 4'd9 : load_minutes;
      sh_d    = (load_sec_high > 4'd5) ? 4'd5 : load_sec_high;
      sl_d    = (load_sec_low > 4'd9)  ? 4'd9 : load_sec_low;
      t_d     = (load_tenths > 4'd9)   ? 4'd9 : load_tenths;
      presc_d = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A zero preset never starts, so Run always holds a non-zero count.
          if (run && !count_zero) state_d = StRun;
        end
        StRun: begin
          if (tick) begin
            presc_d = '0;
            if (t_q != 4'd0) begin
              t_d = t_q - 4'd1;
            end else begin
              t_d = 4'd9;
              if (sl_q != 4'd0) begin
                sl_d = sl_q - 4'd1;
              end else begin
                sl_d = 4'd9;
                if (sh_q != 4'd0) begin
                  sh_d = sh_q - 4'd1;
                end else begin
                  sh_d  = 4'd5;
                  min_d = min_q - 4'd1;
                end
              end
            end
            if (count_one) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else if (!run) begin
              state_d = StPause;
            end
          end else begin
            presc_d = presc_q + 1'b1;
            if (!run) state_d = StPause;
          end
        end
        StPause: begin
          if (run) state_d = StRun;
        end
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end

    running_d = (state_d == StRun);
    expired_d = (state_d == StDone);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      min_q     <= 4'd0;
      sh_q      <= 4'd0;
      sl_q      <= 4'd0;
      t_q       <= 4'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sh_q      <= sh_d;
      sl_q      <= sl_d;
      t_q       <= t_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign minutes  = min_q;
  assign sec_high = sh_q;
  assign sec_low  = sl_q;
  assign tenths   = t_q;
  assign running  = running_q;
  assign expired  = expired_q;
  assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_TENTH = 4. Expected counts come
// from an integer-tenths model and are queued when stimulus is applied, then popped
// whenever the displayed count changes.
module tb_countdown_timer;

  localparam int unsigned T = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load  = 1'b0;
  logic       run   = 1'b0;
  logic [3:0] lm = 4'd0, lsh = 4'd0, lsl = 4'd0, lt = 4'd0;
  logic [3:0] minutes, sec_high, sec_low, tenths;
  logic       running, expired, done;
  logic [15:0] cnt_w;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  countdown_timer #(.TICKS_PER_TENTH(T)) dut (
    .clock        (clock),
    .reset        (reset),
    .load         (load),
    .load_minutes (lm),
    .load_sec_high(lsh),
    .load_sec_low (lsl),
    .load_tenths  (lt),
    .run          (run),
    .minutes      (minutes),
    .sec_high     (sec_high),
    .sec_low      (sec_low),
    .tenths       (tenths),
    .running      (running),
    .expired      (expired),
    .done         (done)
  );

  assign cnt_w = {minutes, sec_high, sec_low, tenths};

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decrement: through integer tenths, not digit borrow logic.
  function automatic logic [15:0] dec_bcd(input logic [15:0] v);
    int t;
    t = int'(v[15:12]) * 600 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]) - 1;
    return {4'(t / 600), 4'((t % 600) / 100), 4'((t % 100) / 10), 4'(t % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    {lm, lsh, lsl, lt} = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Wait (bounded) for the count to change, then pop and compare the expected value.
  task automatic wait_change(input string tag, input int budget, output int cyc);
    logic [15:0] old;
    logic [15:0] e;
    old = cnt_w;
    cyc = 0;
    while (cnt_w === old && cyc < budget) begin
      step();
      cyc++;
    end
    n_assert++;
    assert (cnt_w !== old)
    else begin
      n_fail++;
      $error("FAIL %s timeout: observed %0h expected change after %0d cycles", tag, cnt_w, budget);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk(tag, cnt_w, e);
  endtask

  initial begin
    int  cyc;
    logic seen_done, seen_run, seen_chg;
    logic [15:0] v;

    // Reset state
    step();
    chk("rst cnt", cnt_w, 16'h0000);
    chk("rst running", running, 1'b0);
    chk("rst expired", expired, 1'b0);
    chk("rst done", done, 1'b0);
    reset = 1'b1;
    step();

    // 0:00.3 counts 3,2,1,0 at T-cycle intervals
    do_load(16'h0003);
    chk("t27 load", cnt_w, 16'h0003);
    chk("t27 idle", running, 1'b0);
    run = 1'b1;
    v = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      v = dec_bcd(v);
      exp_q.push_back(v);
    end
    wait_change("t27 tick1", 20, cyc);
    chk("t27 first latency", cyc, T + 1);
    wait_change("t27 tick2", 20, cyc);
    chk("t27 interval2", cyc, T);
    wait_change("t27 tick3", 20, cyc);
    chk("t27 interval3", cyc, T);
    chk("t27 done pulse", done, 1'b1);
    chk("t27 expired", expired, 1'b1);
    chk("t27 not running", running, 1'b0);
    step();
    chk("t27 done cleared", done, 1'b0);
    chk("t27 expired held", expired, 1'b1);
    chk("t27 hold zero", cnt_w, 16'h0000);
    run = 1'b0;

    // Invalid BCD clamps; zero preset never starts
    do_load(16'h97FC);
    chk("t30 clamp", cnt_w, 16'h9599);
    chk("t30 expired cleared", expired, 1'b0);
    run = 1'b1;
    do_load(16'h0000);
    seen_done = 1'b0;
    seen_run  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen_done |= done;
      seen_run  |= running;
    end
    chk("t30 zero no done", seen_done, 1'b0);
    chk("t30 zero no run", seen_run, 1'b0);
    chk("t30 zero cnt", cnt_w, 16'h0000);
    run = 1'b0;

    // 1:00.0 full countdown
    do_load(16'h1000);
    v = 16'h1000;
    for (int i = 0; i < 600; i++) begin
      v = dec_bcd(v);
      exp_q.push_back(v);
    end
    run = 1'b1;
    wait_change("t28 first 0:59.9", 20, cyc);
    for (int i = 1; i < 600; i++) wait_change("t28 tick", 2 * T, cyc);
    chk("t28 final done", done, 1'b1);
    chk("t28 final expired", expired, 1'b1);
    chk("t28 queue drained", exp_q.size(), 0);
    run = 1'b0;

    // Pause after 2 Run cycles, resume needs only the remaining 2 Run cycles
    do_load(16'h0050);
    run = 1'b1;
    step();
    chk("t29 entered run", running, 1'b1);
    step();
    run = 1'b0;
    step();
    chk("t29 paused", running, 1'b0);
    seen_chg = 1'b0;
    seen_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen_chg |= (cnt_w !== 16'h0050);
      seen_run |= running;
    end
    chk("t29 digits held", seen_chg, 1'b0);
    chk("t29 stayed paused", seen_run, 1'b0);
    exp_q.push_back(dec_bcd(16'h0050));
    run = 1'b1;
    wait_change("t29 resume tick", 20, cyc);
    chk("t29 resume latency", cyc, 3);
    run = 1'b0;

    // Load during Done restarts cleanly
    do_load(16'h0001);
    run = 1'b1;
    exp_q.push_back(16'h0000);
    wait_change("t32 to zero", 20, cyc);
    repeat (3) step();
    chk("t32 done ignores run", cnt_w, 16'h0000);
    chk("t32 still expired", expired, 1'b1);
    do_load(16'h0050);
    chk("t32 load cnt", cnt_w, 16'h0050);
    chk("t32 expired cleared", expired, 1'b0);
    chk("t32 idle", running, 1'b0);
    exp_q.push_back(dec_bcd(16'h0050));
    wait_change("t32 count resumes", 20, cyc);
    chk("t32 latency", cyc, T + 1);
    run = 1'b0;

    // Asynchronous reset mid-count
    do_load(16'h3215);
    run = 1'b1;
    exp_q.push_back(dec_bcd(16'h3215));
    wait_change("t31 reach 3:21.4", 20, cyc);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("t31 async cnt", cnt_w, 16'h0000);
    chk("t31 async running", running, 1'b0);
    chk("t31 async expired", expired, 1'b0);
    chk("t31 async done", done, 1'b0);
    step();
    reset = 1'b1;
    seen_run = 1'b0;
    seen_chg = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen_run |= running;
      seen_chg |= (cnt_w !== 16'h0000);
    end
    chk("t31 no run after reset", seen_run, 1'b0);
    chk("t31 no count after reset", seen_chg, 1'b0);
    run = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
